// File: rtl/qdiv_scheduler.sv
// Request queue and launch sequencer in front of the sequential qdiv divider.
// Results come back in request order; divide-by-zero and a hung divider are resolved locally.
module qdiv_scheduler #(
   parameter int N          = 32,
   parameter int Q          = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_dividend,
   input  logic [N-1:0] in_divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_quotient,
   output logic [1:0]   out_flags,
   output logic [N-1:0] div_dividend,
   output logic [N-1:0] div_divisor,
   output logic         div_start,
   input  logic [N-1:0] div_quotient,
   input  logic         div_complete,
   output logic         busy
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   generate
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
         $error("FIFO_DEPTH must be a power of two >= 2");
      if (TIMEOUT <= N + Q)
         $error("TIMEOUT must exceed the qdiv latency");
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

   // ---------------- request FIFO ----------------
   logic [FIFO_DEPTH-1:0][2*N-1:0] mem_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] avail_q, avail_d;
   logic          push_q;
   logic          in_ready_q;
   logic          push, pop;

   assign push = in_valid & in_ready_q;

   // Entries become poppable one cycle after they are written, so the FSM
   // tracks a separately lagged occupancy while 'full' uses the live count.
   assign count_d = count_q + CW'(push) - CW'(pop);
   assign avail_d = avail_q + CW'(push_q) - CW'(pop);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_dividend, in_divisor};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         avail_q    <= '0;
         push_q     <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q    <= count_d;
         avail_q    <= avail_d;
         push_q     <= push;
         in_ready_q <= (count_d != CW'(FIFO_DEPTH));
      end
   end

   // ---------------- launch FSM and output register ----------------
   state_t        state_q, state_d;
   logic [N-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
   logic          start_q, start_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          ov_q, ov_d;
   logic [N-1:0]  oq_q, oq_d;
   logic [1:0]    of_q, of_d;
   logic [N-1:0]  head_a, head_b;

   assign head_a = mem_q[rd_ptr_q][2*N-1:N];
   assign head_b = mem_q[rd_ptr_q][N-1:0];
   assign pop    = (state_q == S_IDLE) && (avail_q != '0) && !ov_q;

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      start_d = start_q;
      cnt_d   = cnt_q;
      ov_d    = ov_q & ~out_ready;
      oq_d    = oq_q;
      of_d    = of_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               if (head_b[N-2:0] == '0) begin
                  ov_d = 1'b1;
                  oq_d = {head_a[N-1] ^ head_b[N-1], {(N-1){1'b1}}};
                  of_d = 2'b01;
               end else begin
                  dvd_d   = head_a;
                  dvs_d   = head_b;
                  start_d = 1'b1;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + TW'(1);
            // Output register is always empty here: pop required it and nothing else loads it.
            if (div_complete) begin
               ov_d    = 1'b1;
               oq_d    = div_quotient;
               of_d    = 2'b00;
               start_d = 1'b0;
               state_d = S_DRAIN;
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
               ov_d    = 1'b1;
               oq_d    = '0;
               of_d    = 2'b10;
               start_d = 1'b0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         start_q <= 1'b0;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
         oq_q    <= '0;
         of_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
         ov_q    <= ov_d;
         oq_q    <= oq_d;
         of_q    <= of_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = ov_q;
   assign out_quotient = oq_q;
   assign out_flags    = of_q;
   assign div_dividend = dvd_q;
   assign div_divisor  = dvs_q;
   assign div_start    = start_q;
   assign busy         = (count_q != '0) || (state_q != S_IDLE) || ov_q;

endmodule

// File: tb/tb_qdiv_scheduler.sv
// Scoreboard bench for qdiv_scheduler with a behavioural 40-cycle qdiv stand-in.
module tb_qdiv_scheduler;
   localparam int N = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  in_dividend = '0, in_divisor = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [N-1:0]  out_quotient;
   logic [1:0]    out_flags;
   logic [N-1:0]  div_dividend, div_divisor;
   logic          div_start;
   logic [N-1:0]  div_quotient;
   logic          div_complete;
   logic          busy;

   typedef struct packed { logic [N-1:0] q; logic [1:0] f; } exp_t;
   exp_t sb[$];

   int  n_chk = 0, n_err = 0;
   int  start_cnt = 0;
   int  m_cnt;
   logic hang = 1'b0;

   always #5 clk = ~clk;

   qdiv_scheduler #(.N(N), .Q(8), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_dividend(in_dividend), .in_divisor(in_divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_quotient(out_quotient), .out_flags(out_flags),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_start(div_start), .div_quotient(div_quotient),
      .div_complete(div_complete), .busy(busy)
   );

   function automatic logic [N-1:0] qref(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [63:0] num, mag;
      num = {33'd0, a[30:0]} << 8;
      mag = num / {33'd0, b[30:0]};
      return {a[31] ^ b[31], mag[30:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // behavioural divider: complete 40 cycles after start, held until start drops
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt <= 0; div_complete <= 1'b0; div_quotient <= '0;
      end else if (!div_start) begin
         m_cnt <= 0; div_complete <= 1'b0;
      end else if (m_cnt == 39) begin
         if (!hang) begin
            div_complete <= 1'b1;
            div_quotient <= qref(div_dividend, div_divisor);
            m_cnt <= m_cnt + 1;
         end
      end else if (m_cnt < 39) begin
         m_cnt <= m_cnt + 1;
      end
   end

   always @(posedge clk) if (div_start) start_cnt <= start_cnt + 1;

   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_unexpected", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("quot", out_quotient, e.q);
            chk("flags", out_flags, e.f);
         end
      end
   end

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input exp_t e);
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 400) begin @(negedge clk); t++; end
      if (!in_ready) begin chk("in_ready_timeout", 0, 1); return; end
      in_valid = 1'b1; in_dividend = a; in_divisor = b;
      @(posedge clk);
      sb.push_back(e);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_div(input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      if (b[30:0] == 0) e = '{q: {a[31] ^ b[31], {31{1'b1}}}, f: 2'b01};
      else if (hang)    e = '{q: '0, f: 2'b10};
      else              e = '{q: qref(a, b), f: 2'b00};
      send(a, b, e);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || busy) && t < 2000) begin @(posedge clk); t++; end
      chk("drain_timeout", (sb.size() == 0 && !busy), 1);
   endtask

   initial begin
      int s0, t, acc;
      logic [N-1:0] hq;
      logic [1:0]   hf;

      // reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);

      // 1: 12/3 with launch timing
      send_div(32'h0000_0C00, 32'h0000_0300);
      @(negedge clk);
      @(negedge clk); chk("start_k1", div_start, 0);
      @(negedge clk); chk("start_k2", div_start, 1);
      chk("div_dividend", div_dividend, 32'h0000_0C00);
      t = 0;
      while (!div_complete && t < 200) begin @(negedge clk); t++; end
      chk("complete_seen", div_complete, 1);
      @(negedge clk);
      chk("start_drop", div_start, 0);
      chk("ov_after_complete", out_valid, 1);
      wait_drain();

      // 2: fill the queue with the output port stalled
      @(posedge clk); #1 out_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         send_div(((i * 7 + 3) << 8) | (i[0] ? 32'h8000_0000 : 32'h0), (i + 1) << 8);
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      @(posedge clk); #1 out_ready = 1'b1;
      send_div(32'h8000_1900, 32'h0000_0500);
      wait_drain();

      // 3: divide by zero
      s0 = start_cnt;
      send_div(32'h8000_0500, 32'h0000_0000);
      @(negedge clk); chk("dz_no_ov_yet", out_valid, 0);
      wait_drain();
      chk("dz_no_start", start_cnt - s0, 0);

      // 4: hung divider then normal recovery
      hang = 1'b1;
      s0 = start_cnt;
      send_div(32'h0000_0C00, 32'h0000_0300);
      wait_drain();
      chk("timeout_cycles", start_cnt - s0, 64);
      hang = 1'b0;
      send_div(32'h0000_0C00, 32'h0000_0300);
      wait_drain();

      // 5: stalled result stays put and blocks the next launch
      @(posedge clk); #1 out_ready = 1'b0;
      send_div(32'h0000_2800, 32'h0000_0400);
      send_div(32'h0000_0C00, 32'h0000_0300);
      t = 0;
      while (!out_valid && t < 200) begin @(negedge clk); t++; end
      chk("stall_ov", out_valid, 1);
      hq = out_quotient; hf = out_flags;
      chk("stall_q_ref", hq, 32'h0000_0A00);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stall_q", out_quotient, hq);
         chk("stall_f", out_flags, hf);
         chk("stall_start", {out_valid, div_start}, 2'b10);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 chk("pop_after_ready", div_start, 1);
      wait_drain();

      // 6: reset mid-WAIT
      send_div(32'h0000_0C00, 32'h0000_0300);
      send_div(32'h0000_0C00, 32'h0000_0300);
      repeat (10) @(posedge clk);
      @(negedge clk) reset_n = 1'b0;
      #1;
      chk("mid_rst_start", div_start, 0);
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_dvd", div_dividend, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      sb.delete();
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      send_div(32'h0000_0C00, 32'h0000_0300);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
